filter_frame_ctrl: RTL

FILTER_FRAME_CTRL -- requirements
Module: filter_frame_ctrl

---
 rtl/filter_frame_ctrl.sv | 175 +++++++++++++++++
 1 files changed

// File: rtl/filter_frame_ctrl.sv
// Frame sequencing controller for a 3x3 sliding-window filter: line-buffer strobes, window coordinates and frame status.
// Optional backpressure stall counter is built when FRAME_CTRL_STALL_CNT_EN is defined.
module filter_frame_ctrl #(
    parameter int ROWS = 400,
    parameter int COLS = 400
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start_i,
    input  logic        pix_valid_i,
    output logic        pix_ready_o,
    input  logic        out_ready_i,
    output logic        shift_en_o,
    output logic        lb_wr_en_o,
    output logic [9:0]  lb_addr_o,
    output logic        win_valid_o,
    output logic [9:0]  win_row_o,
    output logic [9:0]  win_col_o,
    output logic        busy_o,
    output logic        frame_done_o,
    output logic [15:0] stall_cnt_o
);

    localparam logic [17:0] FILL_LAST = 18'(COLS);
    localparam logic [17:0] PIX_LAST  = 18'(ROWS * COLS - 1);
    localparam logic [10:0] DRAIN_LAST = 11'(COLS);
    localparam logic [9:0]  COL_LAST  = 10'(COLS - 1);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        FILL  = 3'd1,
        RUN   = 3'd2,
        DRAIN = 3'd3,
        DONE  = 3'd4
    } state_t;

    state_t      state;
    logic [17:0] pix_cnt;
    logic [10:0] drain_cnt;
    logic [9:0]  col_cnt;
    logic [9:0]  nxt_row;
    logic [9:0]  nxt_col;
    logic        win_vld_p1;
    logic [9:0]  win_row_p1;
    logic [9:0]  win_col_p1;
    logic        emit;

    // Handshake strobes follow the registered state and the live input handshake.
    always_comb begin
        pix_ready_o = 1'b0;
        shift_en_o  = 1'b0;
        lb_wr_en_o  = 1'b0;
        if (!rst) begin
            unique case (state)
                FILL: begin
                    pix_ready_o = 1'b1;
                    shift_en_o  = pix_valid_i;
                    lb_wr_en_o  = pix_valid_i;
                end
                RUN: begin
                    pix_ready_o = out_ready_i;
                    shift_en_o  = pix_valid_i && out_ready_i;
                    lb_wr_en_o  = pix_valid_i && out_ready_i;
                end
                DRAIN: begin
                    shift_en_o  = out_ready_i;
                end
                default: begin
                    pix_ready_o = 1'b0;
                end
            endcase
        end
    end

    assign emit         = shift_en_o && ((state == RUN) || (state == DRAIN));
    assign busy_o       = !rst && ((state == FILL) || (state == RUN) || (state == DRAIN));
    assign frame_done_o = !rst && (state == DONE);
    assign lb_addr_o    = col_cnt;
    assign win_valid_o  = win_vld_p1;
    assign win_row_o    = win_row_p1;
    assign win_col_o    = win_col_p1;

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            pix_cnt    <= '0;
            drain_cnt  <= '0;
            col_cnt    <= '0;
            nxt_row    <= '0;
            nxt_col    <= '0;
            win_vld_p1 <= 1'b0;
            win_row_p1 <= '0;
            win_col_p1 <= '0;
        end else begin
            win_vld_p1 <= 1'b0;

            if (shift_en_o) begin
                col_cnt <= (col_cnt == COL_LAST) ? 10'd0 : col_cnt + 10'd1;
            end

            // Stage p1: window coordinates are presented one cycle after the strobe that completes them.
            if (emit) begin
                win_vld_p1 <= 1'b1;
                win_row_p1 <= nxt_row;
                win_col_p1 <= nxt_col;
                if (nxt_col == COL_LAST) begin
                    nxt_col <= '0;
                    nxt_row <= nxt_row + 10'd1;
                end else begin
                    nxt_col <= nxt_col + 10'd1;
                end
            end

            unique case (state)
                IDLE: begin
                    if (start_i) begin
                        state     <= FILL;
                        pix_cnt   <= '0;
                        drain_cnt <= '0;
                        col_cnt   <= '0;
                        nxt_row   <= '0;
                        nxt_col   <= '0;
                    end
                end
                FILL: begin
                    if (shift_en_o) begin
                        pix_cnt <= pix_cnt + 18'd1;
                        if (pix_cnt == FILL_LAST) state <= RUN;
                    end
                end
                RUN: begin
                    if (shift_en_o) begin
                        pix_cnt <= pix_cnt + 18'd1;
                        if (pix_cnt == PIX_LAST) state <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (shift_en_o) begin
                        drain_cnt <= drain_cnt + 11'd1;
                        if (drain_cnt == DRAIN_LAST) state <= DONE;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

`ifdef FRAME_CTRL_STALL_CNT_EN
    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    logic [15:0] stall_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt <= '0;
        end else if ((state == IDLE) && start_i) begin
            stall_cnt <= '0;
        end else if ((state == RUN) && pix_valid_i && !out_ready_i) begin
            stall_cnt <= sat_inc16(stall_cnt);
        end
    end

    assign stall_cnt_o = stall_cnt;
`else
    assign stall_cnt_o = 16'h0000;
`endif

endmodule
